// File: rtl/shiftreg_frame_pkg.sv
// Shared types and elaboration helpers for the framed shift register.
package shiftreg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int beats(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/shiftreg_frame_if.sv
// Parallel-load, serial-lane and frame-result signals of shiftreg_frame.
interface shiftreg_frame_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 1
);

  logic             ena;
  logic             dir;
  logic             rot;
  logic [WIDTH-1:0] par_in;
  logic             par_in_valid;
  logic             par_in_ready;
  logic [LANES-1:0] ser_in;
  logic [LANES-1:0] ser_out;
  logic [WIDTH-1:0] qpar;
  logic [WIDTH-1:0] par_out;
  logic             par_out_valid;
  logic             busy;

  modport master (
    output ena, dir, rot, par_in, par_in_valid, ser_in,
    input  par_in_ready, ser_out, qpar, par_out, par_out_valid, busy
  );

  modport slave (
    input  ena, dir, rot, par_in, par_in_valid, ser_in,
    output par_in_ready, ser_out, qpar, par_out, par_out_valid, busy
  );

endinterface

// File: rtl/shiftreg_beat_cnt.sv
// Beat counter for one frame: clear wins over enable, last flags beat BEATS-1.
// Zero-latency last flag (decoded from the registered count); no backpressure.
module shiftreg_beat_cnt #(
  parameter int BEATS = 16
) (
  input  logic clk,
  input  logic aclr,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = $clog2(BEATS);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(BEATS - 1));

endmodule

// File: rtl/shiftreg_frame.sv
// Framed LANES-wide serializer/deserializer; ser_out valid 1 cycle after load, par_out pulse 1 cycle after last beat.
// Load stalls via par_in_ready; par_out has no backpressure. SHIFTREG_FRAME_ROTATE_EN builds lane recirculation.
module shiftreg_frame
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LANES = 1
) (
  input logic             clk,
  input logic             aclr,
  shiftreg_frame_if.slave bus
);

  localparam int BEATS = beats(WIDTH, LANES);

  if ((WIDTH % LANES) != 0 || BEATS < 2) begin : g_bad_params
    $error("shiftreg_frame: WIDTH must be a multiple of LANES with at least two beats");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             dir_q, dir_d;
  logic             pov_q, pov_d;
  logic             rot_q;

  logic [WIDTH-1:0] shifted;
  logic [LANES-1:0] ser_out_w;
  logic [LANES-1:0] in_lanes;
  logic             accept;
  logic             beat;
  logic             last;
  logic             frame_done;

  assign beat       = (state_q == RUN) && bus.ena;
  assign frame_done = beat && last;
  // Ready depends on ena and the count, never on par_in_valid.
  assign bus.par_in_ready = (state_q == IDLE) || frame_done;
  assign accept     = bus.par_in_valid && bus.par_in_ready;

  assign ser_out_w = dir_q ? shift_q[WIDTH-1 -: LANES] : shift_q[LANES-1:0];
  assign in_lanes  = rot_q ? ser_out_w : bus.ser_in;
  assign shifted   = dir_q ? {shift_q[WIDTH-LANES-1:0], in_lanes}
                           : {in_lanes, shift_q[WIDTH-1:LANES]};

`ifdef SHIFTREG_FRAME_ROTATE_EN
  logic rot_d;

  always_comb begin
    rot_d = rot_q;
    if (accept) begin
      rot_d = bus.rot;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rot_q <= 1'b0;
    end else begin
      rot_q <= rot_d;
    end
  end
`else
  logic unused_rot;

  assign rot_q      = 1'b0;
  assign unused_rot = bus.rot;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    dir_d     = dir_q;
    par_out_d = par_out_q;
    pov_d     = frame_done;
    if (beat) begin
      shift_d = shifted;
    end
    if (frame_done) begin
      par_out_d = shifted;
      state_d   = IDLE;
    end
    // A load on the final beat overrides the shifted value and keeps RUN.
    if (accept) begin
      shift_d = bus.par_in;
      dir_d   = bus.dir;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      dir_q     <= 1'b0;
      par_out_q <= '0;
      pov_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      dir_q     <= dir_d;
      par_out_q <= par_out_d;
      pov_q     <= pov_d;
    end
  end

  shiftreg_beat_cnt #(
    .BEATS(BEATS)
  ) u_beat_cnt (
    .clk  (clk),
    .aclr (aclr),
    .clr  (accept || frame_done),
    .en   (beat),
    .last (last)
  );

  assign bus.ser_out       = ser_out_w;
  assign bus.qpar          = shift_q;
  assign bus.par_out       = par_out_q;
  assign bus.par_out_valid = pov_q;
  assign bus.busy          = (state_q == RUN);

endmodule

// File: doc/shiftreg_frame.md
# shiftreg_frame

Framed, lane-parallel serializer/deserializer shift register. It is the parametrised successor of the plain single-bit shift register. It moves LANES bits per enabled beat and counts beats to a full frame, with a valid/ready parallel-load handshake and a registered parallel-out snapshot plus one-cycle completion pulse. It sits between byte/word-oriented logic and serial links such as SPI, LVDS lanes or bit-banged buses.

## Interface
- WIDTH, 16: register width in bits; WIDTH % LANES == 0 and WIDTH/LANES >= 2, checked at elaboration with $error.
- LANES, 1: bits shifted per enabled beat.
- BEATS (localparam) = WIDTH/LANES; counter width $clog2(BEATS).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- aclr  in  1  reset, asynchronous, active-high.
- ena  in  1  beat enable; one shift per cycle when high in RUN.
- dir  in  1  1 = shift toward MSB (ser_out from MSB lanes, ser_in into LSB lanes); 0 = toward LSB. Sampled only at load acceptance.
- rot  in  1  rotate request, sampled at load acceptance (see Configuration).
- par_in  in  WIDTH  word to serialize.
- par_in_valid  in  1  load request.
- par_in_ready  out  1  load accepted this cycle when valid & ready.
- ser_in  in  LANES  serial input lanes.
- ser_out  out  LANES  serial output lanes.
- qpar  out  WIDTH  live register contents.
- par_out  out  WIDTH  snapshot of register after final beat of a frame.
- par_out_valid  out  1  one-cycle pulse; par_out updated this cycle.
- busy  out  1  high in RUN.

## Operation
- States: IDLE, RUN. Reset → IDLE.
- Reset values: shift=0, cnt=0, dir_q=0, rot_q=0, par_out=0, par_out_valid=0, busy=0; par_in_ready=1 in IDLE.
- par_in_ready (combinational) = IDLE | (RUN & ena & cnt==BEATS-1).
- Accept (valid & ready): shift<=par_in, dir_q<=dir, rot_q<=rot, cnt<=0, state<=RUN.
- RUN & ena: dir_q=1 → shift<={shift[WIDTH-LANES-1:0], in}; dir_q=0 → shift<={in, shift[WIDTH-1:LANES]}. Here in = ser_in, or the outgoing lanes when rotating. cnt<=cnt+1.
- RUN & ena & cnt==BEATS-1: par_out<=post-shift value, par_out_valid<=1 next cycle. State goes to RUN if a load is accepted in the same cycle (load wins over shift for register contents, cnt<=0), else IDLE with cnt<=0.
- RUN & !ena: register, cnt and state hold.
- IDLE & ena: ignored; register holds.
- ser_out = dir_q ? shift[WIDTH-1 -: LANES] : shift[LANES-1:0] (combinational from register).
- par_out has no backpressure; the consumer must take the pulse.
- aclr at any time aborts the frame: all registers go to reset values and no par_out_valid is issued.

## Timing
- Load-to-first-bit: ser_out is valid the cycle after acceptance.
- Frame: exactly BEATS enabled cycles; par_out_valid is asserted the cycle after the final enabled beat.
- Back-to-back frames: zero idle cycles; busy stays 1 across the boundary.
- par_in_ready depends combinationally on ena; there is no combinational path from par_in_valid to any output.

## Configuration
- SHIFTREG_FRAME_ROTATE_EN defined: rot_q=1 recirculates the outgoing lanes into the incoming lanes and ignores ser_in; after a frame, par_out equals the loaded word.
- Undefined: rotate logic is not built, rot is ignored (rot_q tied 0), and ser_in always feeds the register.

## Structure
- Package shiftreg_pkg holds the state_t enum (IDLE, RUN) and the helper function beats(WIDTH, LANES).
- Sub-module shiftreg_beat_cnt: clear/enable beat counter with a last flag at BEATS-1, parametrised by BEATS.

## Test plan
- WIDTH=8, LANES=1, load 0xA5 with dir=1, ser_in stream 1,1,0,0,1,1,0,0 → ser_out 1,0,1,0,0,1,0,1; par_out=0xCC with a single par_out_valid pulse after the 8th beat; busy then 0.
- WIDTH=8, LANES=2, load 0x1B with dir=0, ser_in=0 → ser_out 3,2,1,0; par_out=0x00 after 4 beats.
- Hold par_in_valid with 0x5A through the last beat of a frame → par_in_ready=1 on that cycle; next cycle qpar=0x5A, cnt=0, busy stays 1, par_out_valid=1.
- ena low for 3 cycles mid-frame → qpar and cnt unchanged; par_out_valid appears only after the 8th enabled beat.
- aclr asserted after beat 4 → qpar=0, busy=0, par_in_ready=1, no par_out_valid.
- With the macro, rot=1, load 0x81, dir=1, 8 beats, ser_in=1 → par_out=0x81. Without the macro, the same stimulus gives par_out=0xFF.
